uart_tx_buffered: RTL and testbench



---
 rtl/uart_tx_buffered_if.sv | 17 +
 rtl/uart_tx_buffered.sv | 113 +++++++++++
 tb/tb_uart_tx_buffered.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: producer-side handshake and serial outputs of the buffered UART transmitter
//   TX_Data_in  word to send, sampled on an accepted TX_en
//   TX_en       write strobe
//   TX_Ready    holding buffer empty, a write is accepted this cycle
//   TX_Busy     a frame is on the line
//   TX_Data_out serial line, idle high
interface uart_tx_buffered_if #(
    parameter int WORD_SIZE = 8
);
    logic [WORD_SIZE-1:0] TX_Data_in;
    logic                 TX_en;
    logic                 TX_Ready;
    logic                 TX_Busy;
    logic                 TX_Data_out;
    modport master (output TX_Data_in, TX_en, input TX_Ready, TX_Busy, TX_Data_out);
    modport slave  (input TX_Data_in, TX_en, output TX_Ready, TX_Busy, TX_Data_out);
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: UART transmitter with baud counter, optional parity, 1-2 stop bits and a one-word holding buffer
//   clk      system clock
//   reset_b  synchronous active-low reset
//   bus      slave side of uart_tx_buffered_if (TX_Data_in, TX_en in; TX_Ready, TX_Busy, TX_Data_out out)
module uart_tx_buffered #(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input logic               clk,
    input logic               reset_b,
    uart_tx_buffered_if.slave bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WORD_SIZE + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [BAUD_W-1:0]    baud_cnt, baud_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [WORD_SIZE-1:0] shifter, shift_n, hold_data, hold_n;
    logic                 hold_valid, hv_n, par_q, par_n, line_q, line_n;
    logic                 baud_end, last_data, last_stop, load;

    assign baud_end  = baud_cnt == BAUD_W'(CLKS_PER_BIT - 1);
    assign last_data = bit_cnt == BIT_W'(WORD_SIZE - 1);
    assign last_stop = bit_cnt == BIT_W'(STOP_BITS - 1);
    // The held word goes out from idle, or straight after the final stop bit with no idle gap.
    assign load      = hold_valid && (state == IDLE || (state == STOP && baud_end && last_stop));

    assign bus.TX_Ready    = !hold_valid;
    assign bus.TX_Busy     = state != IDLE;
    assign bus.TX_Data_out = line_q;

    always_comb begin
        state_n = state;
        baud_n  = (state == IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shifter;
        hold_n  = hold_data;
        hv_n    = hold_valid;
        par_n   = par_q;
        line_n  = line_q;
        case (state)
            START: if (baud_end) begin
                state_n = DATA;
                bit_n   = '0;
                line_n  = shifter[0];
            end
            DATA: if (baud_end) begin
                shift_n = shifter >> 1;
                if (last_data) begin
                    bit_n   = '0;
                    state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    line_n  = (PARITY_EN != 0) ? par_q : 1'b1;
                end else begin
                    bit_n  = bit_cnt + 1'b1;
                    line_n = shifter[1];
                end
            end
            PARITY: if (baud_end) begin
                state_n = STOP;
                line_n  = 1'b1;
            end
            STOP: if (baud_end) begin
                bit_n = bit_cnt + 1'b1;
                if (last_stop) begin
                    state_n = IDLE;
                    line_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = START;
            shift_n = hold_data;
            par_n   = (^hold_data) ^ 1'(PARITY_ODD);
            hv_n    = 1'b0;
            bit_n   = '0;
            line_n  = 1'b0;
        end
        // Accept only when empty; load requires a full buffer, so the two never coincide.
        if (bus.TX_en && !hold_valid) begin
            hv_n   = 1'b1;
            hold_n = bus.TX_Data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shifter    <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            par_q      <= 1'b0;
            line_q     <= 1'b1;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shifter    <= shift_n;
            hold_data  <= hold_n;
            hold_valid <= hv_n;
            par_q      <= par_n;
            line_q     <= line_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: checks three transmitter configurations against a frame-level model plus literal expectations
module tb_uart_tx_buffered;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic [7:0] din = 8'h00;
    logic       en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_buffered_if #(.WORD_SIZE(8)) b0 ();
    uart_tx_buffered_if #(.WORD_SIZE(8)) b1 ();
    uart_tx_buffered_if #(.WORD_SIZE(8)) b2 ();

    assign b0.TX_Data_in = din;
    assign b0.TX_en      = en;
    assign b1.TX_Data_in = din;
    assign b1.TX_en      = en;
    assign b2.TX_Data_in = din;
    assign b2.TX_en      = en;

    uart_tx_buffered #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut0 (.clk(clk), .reset_b(reset_b), .bus(b0.slave));
    uart_tx_buffered #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
        dut1 (.clk(clk), .reset_b(reset_b), .bus(b1.slave));
    uart_tx_buffered #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
        dut2 (.clk(clk), .reset_b(reset_b), .bus(b2.slave));

    logic [2:0] line, rdy, bsy;
    assign line = {b2.TX_Data_out, b1.TX_Data_out, b0.TX_Data_out};
    assign rdy  = {b2.TX_Ready, b1.TX_Ready, b0.TX_Ready};
    assign bsy  = {b2.TX_Busy, b1.TX_Busy, b0.TX_Busy};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int i, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %b want %b at %0t", nm, i, got, want, $time);
        end
    endtask

    // Frame model: a frame is a list of line bits, each held CPB clocks.
    int         pe_a[3] = '{0, 1, 1};
    int         po_a[3] = '{0, 0, 1};
    int         sb_a[3] = '{1, 2, 2};
    bit         m_act[3];
    bit         m_hv[3];
    int         m_t[3];
    int         m_len[3];
    logic [15:0] m_bits[3];
    logic [7:0] m_hd[3];
    bit         started = 1'b0;

    function automatic logic [15:0] frame(input logic [7:0] w, input int pe, input int po);
        logic [15:0] f;
        f = {7'h7F, w, 1'b0};
        if (pe != 0) f[9] = 1'(($countones(w) % 2) ^ po);
        return f;
    endfunction

    always @(posedge clk) begin
        bit old;
        started = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!reset_b) begin
                m_act[i] = 1'b0;
                m_hv[i]  = 1'b0;
                m_t[i]   = 0;
            end else begin
                old = m_hv[i];
                if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] == m_len[i] * CPB) m_act[i] = 1'b0;
                end
                if (!m_act[i] && old) begin
                    m_bits[i] = frame(m_hd[i], pe_a[i], po_a[i]);
                    m_len[i]  = 9 + pe_a[i] + sb_a[i];
                    m_t[i]    = 0;
                    m_act[i]  = 1'b1;
                    m_hv[i]   = 1'b0;
                end
                if (en && !old) begin
                    m_hv[i] = 1'b1;
                    m_hd[i] = din;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                check("model line", i, line[i], m_act[i] ? m_bits[i][4'(m_t[i] / CPB)] : 1'b1);
                check("model ready", i, rdy[i], !m_hv[i]);
                check("model busy", i, bsy[i], m_act[i]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        din = w;
        en  = 1'b1;
        step(1);
        en  = 1'b0;
    endtask

    logic [9:0] exp_a5 = 10'b1101001010;
    logic [7:0] w22 = 8'h22;

    initial begin
        // Reset and idle hold
        step(3);
        reset_b = 1'b1;
        step(10);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst line", i, line[i], 1'b1);
            check("rst ready", i, rdy[i], 1'b1);
            check("rst busy", i, bsy[i], 1'b0);
        end
        // Single frame 0xA5
        send(8'hA5);
        @(negedge clk);
        check("a5 ready after accept", 0, rdy[0], 1'b0);
        check("a5 line before start", 0, line[0], 1'b1);
        step(1);
        @(negedge clk);
        check("a5 start", 0, line[0], 1'b0);
        check("a5 ready again", 0, rdy[0], 1'b1);
        check("a5 busy", 0, bsy[0], 1'b1);
        step(1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("a5 bit", 0, line[0], exp_a5[k[3:0]]);
            if (k < 9) step(4);
        end
        step(2);
        @(negedge clk);
        check("a5 busy clk40", 0, bsy[0], 1'b1);
        step(1);
        @(negedge clk);
        check("a5 idle clk41", 0, bsy[0], 1'b0);
        step(20);
        // Back-to-back 0x00 then 0xFF
        send(8'h00);
        step(9);
        send(8'hFF);
        step(30);
        @(negedge clk);
        check("b2b stop", 0, line[0], 1'b1);
        check("b2b busy stop", 0, bsy[0], 1'b1);
        step(1);
        @(negedge clk);
        check("b2b start2", 0, line[0], 1'b0);
        check("b2b busy start2", 0, bsy[0], 1'b1);
        step(39);
        @(negedge clk);
        check("b2b busy clk80", 0, bsy[0], 1'b1);
        step(1);
        @(negedge clk);
        check("b2b idle clk81", 0, bsy[0], 1'b0);
        step(40);
        // Parity and two stop bits with 0x07
        send(8'h07);
        step(38);
        @(negedge clk);
        check("par even", 1, line[1], 1'b1);
        check("par odd", 2, line[2], 1'b0);
        step(3);
        @(negedge clk);
        check("p07 no-par idle", 0, bsy[0], 1'b0);
        check("p07 stop1", 1, line[1], 1'b1);
        check("p07 busy stop1", 1, bsy[1], 1'b1);
        step(7);
        @(negedge clk);
        check("p07 stop2", 1, line[1], 1'b1);
        check("p07 busy clk48", 1, bsy[1], 1'b1);
        check("p07 busy clk48", 2, bsy[2], 1'b1);
        step(1);
        @(negedge clk);
        check("p07 idle clk49", 1, bsy[1], 1'b0);
        check("p07 idle clk49", 2, bsy[2], 1'b0);
        step(5);
        // Queued word plus a dropped write
        send(8'h11);
        step(1);
        send(8'h22);
        @(negedge clk);
        check("q ready low", 0, rdy[0], 1'b0);
        send(8'h55);
        step(43);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("q 0x22 bit", 0, line[0], w22[j[2:0]]);
            if (j < 7) step(4);
        end
        step(7);
        @(negedge clk);
        check("q idle after two", 0, bsy[0], 1'b0);
        step(40);
        @(negedge clk);
        check("q no 0x55 busy", 0, bsy[0], 1'b0);
        check("q no 0x55 line", 0, line[0], 1'b1);
        check("q ready", 0, rdy[0], 1'b1);
        step(5);
        // Reset mid-frame with a word held
        send(8'hA5);
        step(1);
        send(8'h3C);
        step(16);
        reset_b = 1'b0;
        step(1);
        reset_b = 1'b1;
        @(negedge clk);
        check("mid rst line", 0, line[0], 1'b1);
        check("mid rst ready", 0, rdy[0], 1'b1);
        check("mid rst busy", 0, bsy[0], 1'b0);
        check("mid rst busy", 1, bsy[1], 1'b0);
        step(100);
        @(negedge clk);
        check("post rst busy", 0, bsy[0], 1'b0);
        check("post rst line", 0, line[0], 1'b1);
        check("post rst ready", 0, rdy[0], 1'b1);
        check("post rst busy", 2, bsy[2], 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
